// File: rtl/ext_mem_responder_pkg.sv
// Shared constants and types for the external memory responder.
// The package name irb_pkg is the one the rest of the codebase imports.
package irb_pkg;

    localparam int EXTMEM_DW   = 32;
    localparam int MEM_AW_DEF  = 14;
    localparam int RD_LAT_DEF  = 2;
    localparam int Q_DEPTH_DEF = 4;

    // Request record for the default array size.
    typedef struct packed {
        logic                  wr;
        logic [MEM_AW_DEF-1:0] addr;
        logic [EXTMEM_DW-1:0]  data;
    } ext_req_t;

    // True when any address bit above the array index is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
        return (addr >> aw) != 32'd0;
    endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// Request/response bus between a requester and the external memory responder.
interface ext_mem_responder_if;
    import irb_pkg::*;

    logic                 request_extmem;
    logic                 write_extmem;
    logic [31:0]          addr_extmem;
    logic [EXTMEM_DW-1:0] w_data;
    logic                 valid_extmem;
    logic [EXTMEM_DW-1:0] data_extmem;

    modport slave (
        input  request_extmem, write_extmem, addr_extmem, w_data,
        output valid_extmem, data_extmem
    );

    modport master (
        output request_extmem, write_extmem, addr_extmem, w_data,
        input  valid_extmem, data_extmem
    );

endinterface

// File: rtl/ext_mem_responder_array.sv
// Backing store: synchronous single-port RAM, one-cycle read, write-first.
module ext_mem_array #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
                rdata_q     <= wdata;
            end else begin
                rdata_q     <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// External memory responder: request queue with empty-queue bypass, single
// issue per cycle into the backing RAM, and a fixed-latency response pipeline.
module ext_mem_responder
    import irb_pkg::*;
#(
    parameter int MEM_AW  = MEM_AW_DEF,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int Q_DEPTH = Q_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    output logic                err_ovf,
    output logic                err_addr,
    ext_mem_responder_if.slave  bus
);

    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = $clog2(Q_DEPTH) + 1;

    typedef struct packed {
        logic                 wr;
        logic [MEM_AW-1:0]    addr;
        logic [EXTMEM_DW-1:0] data;
    } req_t;

    req_t                 q_mem_q [Q_DEPTH];
    logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 err_ovf_q, err_ovf_d, err_addr_q, err_addr_d;
    logic [RD_LAT-1:0]    vld_q, vld_d, wr_q, wr_d;

    req_t                 req_in, iss_req;
    logic                 req_v, q_empty, q_full;
    logic                 pop, bypass, issue, push;
    logic [EXTMEM_DW-1:0] ram_rdata, resp_data;

    always_comb begin
        req_in     = '{wr: bus.write_extmem, addr: bus.addr_extmem[MEM_AW-1:0], data: bus.w_data};
        // Requests are ignored while reset is held so the RAM is never touched.
        req_v      = bus.request_extmem & rst;
        q_empty    = (count_q == '0);
        q_full     = (count_q == CW'(Q_DEPTH));
        pop        = !stall && !q_empty;
        bypass     = !stall && q_empty && req_v;
        issue      = pop || bypass;
        iss_req    = pop ? q_mem_q[rptr_q] : req_in;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push       = req_v && !bypass && (!q_full || pop);

        wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        err_ovf_d  = err_ovf_q  || (req_v && q_full && !pop);
        err_addr_d = err_addr_q || (req_v && addr_out_of_range(bus.addr_extmem, MEM_AW));

        vld_d      = '0;
        wr_d       = '0;
        vld_d[0]   = issue;
        wr_d[0]    = iss_req.wr;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            wr_d[i]  = wr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            err_ovf_q  <= 1'b0;
            err_addr_q <= 1'b0;
            vld_q      <= '0;
            wr_q       <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            err_ovf_q  <= err_ovf_d;
            err_addr_q <= err_addr_d;
            vld_q      <= vld_d;
            wr_q       <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem_q[wptr_q] <= req_in;
        end
    end

    ext_mem_array #(
        .AW (MEM_AW),
        .DW (EXTMEM_DW)
    ) u_array (
        .clk   (clk),
        .en    (issue),
        .we    (iss_req.wr),
        .addr  (iss_req.addr),
        .wdata (iss_req.data),
        .rdata (ram_rdata)
    );

    // RAM output is stage 0 of the data path; later stages delay it to RD_LAT.
    if (RD_LAT > 1) begin : g_dpipe
        logic [EXTMEM_DW-1:0] dpipe_q [RD_LAT-1];
        logic [EXTMEM_DW-1:0] dpipe_d [RD_LAT-1];

        always_comb begin
            dpipe_d[0] = ram_rdata;
            for (int i = 1; i < RD_LAT - 1; i++) begin
                dpipe_d[i] = dpipe_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    dpipe_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    dpipe_q[i] <= dpipe_d[i];
                end
            end
        end

        assign resp_data = dpipe_q[RD_LAT-2];
    end else begin : g_nopipe
        assign resp_data = ram_rdata;
    end

    assign bus.valid_extmem = vld_q[RD_LAT-1];
    assign bus.data_extmem  = (vld_q[RD_LAT-1] && !wr_q[RD_LAT-1]) ? resp_data : '0;
    assign err_ovf          = err_ovf_q;
    assign err_addr         = err_addr_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: directed scenarios plus random traffic checked
// cycle by cycle against a queue/array reference model.
module tb_ext_mem_responder;
    import irb_pkg::*;

    localparam int MEM_AW  = 14;
    localparam int RD_LAT  = 2;
    localparam int Q_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    logic err_ovf, err_addr;

    ext_mem_responder_if bus ();

    ext_mem_responder #(
        .MEM_AW  (MEM_AW),
        .RD_LAT  (RD_LAT),
        .Q_DEPTH (Q_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .err_ovf  (err_ovf),
        .err_addr (err_addr),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mreq_t;

    mreq_t       mq [$];
    logic [31:0] mmem [int];
    bit          exp_v [int];
    logic [31:0] exp_d [int];
    bit          m_ovf, m_eaddr;
    int          cyc;
    int          n_assert, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_issue(input mreq_t r);
        int idx;
        idx = int'(r.addr[MEM_AW-1:0]);
        exp_v[cyc + RD_LAT] = 1'b1;
        if (r.wr) begin
            mmem[idx] = r.data;
            exp_d[cyc + RD_LAT] = 32'h0;
        end else begin
            exp_d[cyc + RD_LAT] = mmem.exists(idx) ? mmem[idx] : 32'h0;
        end
    endtask

    task automatic model_cycle(input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input bit st);
        mreq_t nr;
        nr = '{wr: w, addr: a, data: d};
        if (r && (a >> MEM_AW) != 0) m_eaddr = 1'b1;
        if (!st && mq.size() > 0) begin
            model_issue(mq.pop_front());
            if (r) mq.push_back(nr);
        end else if (!st && r) begin
            model_issue(nr);
        end else if (r) begin
            if (mq.size() >= Q_DEPTH) m_ovf = 1'b1;
            else mq.push_back(nr);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check outputs mid-cycle.
    task automatic step(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit st);
        int pre_cnt;
        bit pre_ovf, pre_eaddr;
        logic [31:0] ev, ed;
        stall              = st;
        bus.request_extmem = r;
        bus.write_extmem   = w;
        bus.addr_extmem    = a;
        bus.w_data         = d;
        if (!rst) begin
            mq.delete();
            exp_v.delete();
            exp_d.delete();
            m_ovf   = 1'b0;
            m_eaddr = 1'b0;
        end
        pre_cnt   = mq.size();
        pre_ovf   = m_ovf;
        pre_eaddr = m_eaddr;
        if (rst) model_cycle(r, w, a, d, st);
        @(negedge clk);
        ev = exp_v.exists(cyc) ? 32'd1 : 32'd0;
        ed = exp_d.exists(cyc) ? exp_d[cyc] : 32'd0;
        chk("valid_extmem", 32'(bus.valid_extmem), ev);
        chk("data_extmem", bus.data_extmem, ed);
        chk("err_ovf", 32'(err_ovf), 32'(pre_ovf));
        chk("err_addr", 32'(err_addr), 32'(pre_eaddr));
        chk("queue_count", 32'(dut.count_q), 32'(pre_cnt));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.request_extmem = 1'b0;
        bus.write_extmem   = 1'b0;
        bus.addr_extmem    = 32'h0;
        bus.w_data         = 32'h0;
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        m_ovf    = 1'b0;
        m_eaddr  = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        rst = 1'b0;
        idle(3);
        rst = 1'b1;

        // Preload words 0..31 with value = address
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 32'(i), 32'(i), 1'b0);
        idle(4);

        // Write-then-read of 0x10
        step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        idle(4);

        // Restore 0x10, then burst of 8 reads
        step(1'b1, 1'b1, 32'h10, 32'h10, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'(i), 32'h0, 1'b0);
        idle(4);

        // Stall with 5 reads into a 4-deep queue
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(i + 8), 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(8);

        // Out-of-range address aliases onto word 4
        step(1'b1, 1'b0, 32'h0001_0004, 32'h0, 1'b0);
        idle(4);

        // Push and pop in the same cycle with two entries queued
        step(1'b1, 1'b0, 32'h14, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h15, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h16, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(6);

        // Reset with requests in flight
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(i + 1), 32'h0, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 32'h5, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        idle(6);

        // Random traffic over the preloaded window
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) a = a | 32'h0004_0000;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a,
                 $urandom, $urandom_range(0, 3) == 0);
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
